zxbus_dma: RTL and testbench

ZXBUS_DMA -- requirements
Module: zxbus_dma

---
 rtl/zxbus_dma_pkg.sv | 15 +
 rtl/zxbus_dma.sv | 148 ++++++++++++++
 tb/tb_zxbus_dma.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zxbus_dma_pkg.sv
// Shared definitions for the ZX-bus <-> NGS memory byte DMA engine.
package zxbus_dma_pkg;

    localparam int unsigned ADDR_W_DEF = 19;
    localparam int unsigned LEN_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ZX,
        MEM,
        FLAG,
        FIN
    } state_e;

endpackage

// File: rtl/zxbus_dma.sv
// Byte-at-a-time DMA between the ZX data port (data_bit handshake) and NGS memory.
// dir 0 moves ZX writes into memory; dir 1 feeds memory bytes to ZX reads.
module zxbus_dma
    import zxbus_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              cpu_clock,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_dir,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [7:0]        data_reg_out,
    input  logic              data_bit,
    output logic [7:0]        data_reg_in,
    output logic              data_bit_in,
    output logic              data_bit_wr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  remaining
);

    state_e state, state_d;
    logic   dir_q;
    logic   abort_pend;
    logic   accept;
    logic   latch_wdata;
    logic   latch_rdata;
    logic   step;
    logic   set_abort;
    logic   set_pend;

    // Next-state and per-cycle action decode
    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        latch_wdata = 1'b0;
        latch_rdata = 1'b0;
        step        = 1'b0;
        set_abort   = 1'b0;
        set_pend    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    accept  = 1'b1;
                    state_d = (cfg_len == '0) ? FIN : WAIT_ZX;
                end
            end
            WAIT_ZX: begin
                if (cfg_abort) begin
                    set_abort = 1'b1;
                    state_d   = FIN;
                end else if (!dir_q && data_bit) begin
                    latch_wdata = 1'b1;
                    state_d     = MEM;
                end else if (dir_q && !data_bit) begin
                    state_d = MEM;
                end
            end
            MEM: begin
                set_pend = cfg_abort;
                if (mem_ack) begin
                    latch_rdata = dir_q;
                    if (abort_pend || cfg_abort) begin
                        set_abort = 1'b1;
                        state_d   = FIN;
                    end else begin
                        state_d = FLAG;
                    end
                end
            end
            FLAG: begin
                if (cfg_abort) begin
                    set_abort = 1'b1;
                    state_d   = FIN;
                end else begin
                    step    = 1'b1;
                    state_d = (remaining == LEN_W'(1)) ? FIN : WAIT_ZX;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The flag load must land before the next WAIT_ZX samples data_bit
    assign data_bit_wr = (state == FLAG) && !cfg_abort;
    assign data_bit_in = (state == FLAG) && dir_q;

    // State and control/status flags
    always_ff @(posedge cpu_clock or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dir_q      <= 1'b0;
            abort_pend <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_d;
            abort_pend <= (state_d == MEM) && (abort_pend || set_pend);
            mem_req    <= (state_d == MEM);
            mem_we     <= (state_d == MEM) && !dir_q;
            done       <= (state == FIN);
            if (accept) begin
                dir_q   <= cfg_dir;
                busy    <= 1'b1;
                aborted <= 1'b0;
            end else begin
                if (state == FIN) busy <= 1'b0;
                if (set_abort) aborted <= 1'b1;
            end
        end
    end

    // Address / length counters and data holding registers
    always_ff @(posedge cpu_clock or posedge rst) begin
        if (rst) begin
            mem_addr    <= '0;
            remaining   <= '0;
            mem_wdata   <= '0;
            data_reg_in <= '0;
        end else begin
            if (accept) begin
                mem_addr  <= cfg_addr;
                remaining <= cfg_len;
            end else if (step) begin
                mem_addr  <= mem_addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            if (latch_wdata) mem_wdata <= data_reg_out;
            if (latch_rdata) data_reg_in <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_zxbus_dma.sv
// Randomized self-checking bench for zxbus_dma with ZX-side and memory-side agents.
module tb_zxbus_dma;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned LEN_W  = 16;

    logic              cpu_clock;
    logic              rst;
    logic [ADDR_W-1:0] cfg_addr;
    logic [LEN_W-1:0]  cfg_len;
    logic              cfg_dir;
    logic              cfg_start;
    logic              cfg_abort;
    logic [7:0]        data_reg_out;
    logic              data_bit;
    logic [7:0]        data_reg_in;
    logic              data_bit_in;
    logic              data_bit_wr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [LEN_W-1:0]  remaining;

    zxbus_dma #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .cpu_clock   (cpu_clock),
        .rst         (rst),
        .cfg_addr    (cfg_addr),
        .cfg_len     (cfg_len),
        .cfg_dir     (cfg_dir),
        .cfg_start   (cfg_start),
        .cfg_abort   (cfg_abort),
        .data_reg_out(data_reg_out),
        .data_bit    (data_bit),
        .data_reg_in (data_reg_in),
        .data_bit_in (data_bit_in),
        .data_bit_wr (data_bit_wr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .remaining   (remaining)
    );

    initial cpu_clock = 1'b0;
    always #5 cpu_clock = ~cpu_clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference expectations and agent state
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [7:0]        exp_wdata_q[$];
    logic [7:0]        zx_tx_q[$];
    logic [7:0]        zx_rx_exp_q[$];
    logic [7:0]        rd_src_q[$];
    logic [7:0]        preset_tx[$];
    bit                cur_dir;
    bit                pend;
    bit                abort_on_req;
    int                cnt;
    int                force_lat = -1;
    int                mem_lat_max = 3;
    int                zx_gap = 3;
    int                zx_wait;
    int                wr_cnt, done_cnt, req_cycles, acc_cnt;
    logic [ADDR_W-1:0] req_addr0;

    task automatic complete_access();
        logic [7:0] d;
        acc_cnt++;
        check("addr_stable", 32'(mem_addr), 32'(req_addr0));
        check("mem_we", 32'(mem_we), 32'(!cur_dir));
        if (exp_addr_q.size() == 0) check("extra_access", 32'd1, 32'd0);
        else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        if (!cur_dir) begin
            if (exp_wdata_q.size() == 0) check("extra_write", 32'd1, 32'd0);
            else check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata_q.pop_front()));
        end else begin
            d = (rd_src_q.size() != 0) ? rd_src_q.pop_front() : 8'($urandom);
            mem_rdata = d;
            zx_rx_exp_q.push_back(d);
        end
    endtask

    // One clock: observe outputs at negedge, then react just after the posedge
    task automatic tick();
        logic o_wr, o_win, o_req, o_done;
        @(negedge cpu_clock);
        o_wr   = data_bit_wr;
        o_win  = data_bit_in;
        o_req  = mem_req;
        o_done = done;
        if (o_wr) begin
            wr_cnt++;
            check("data_bit_in", 32'(o_win), 32'(cur_dir));
        end
        if (o_done) done_cnt++;
        if (o_req) req_cycles++;
        @(posedge cpu_clock);
        #1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        if (o_wr) data_bit = o_win;
        if (mem_ack) begin
            mem_ack = 1'b0;
            pend    = 1'b0;
        end else if (o_req) begin
            if (!pend) begin
                pend      = 1'b1;
                cnt       = (force_lat >= 0) ? force_lat : int'($urandom_range(0, mem_lat_max));
                req_addr0 = mem_addr;
                if (abort_on_req) begin
                    cfg_abort    = 1'b1;
                    abort_on_req = 1'b0;
                end
            end
            if (cnt == 0) begin
                mem_ack = 1'b1;
                complete_access();
            end else begin
                cnt--;
            end
        end
        if (zx_wait > 0) begin
            zx_wait--;
        end else if (!cur_dir) begin
            if (!data_bit && zx_tx_q.size() != 0) begin
                data_reg_out = zx_tx_q.pop_front();
                data_bit     = 1'b1;
                zx_wait      = $urandom_range(0, zx_gap);
            end
        end else if (data_bit) begin
            if (zx_rx_exp_q.size() == 0) check("zx_extra_read", 32'd1, 32'd0);
            else check("zx_read", 32'(data_reg_in), 32'(zx_rx_exp_q.pop_front()));
            data_bit = 1'b0;
            zx_wait  = $urandom_range(0, zx_gap);
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0; done_cnt = 0; req_cycles = 0; acc_cnt = 0;
        pend = 1'b0; zx_wait = 0;
    endtask

    task automatic run_xfer(input bit dir, input logic [ADDR_W-1:0] addr, input int len,
                            input bit glitch, input bit exp_abt);
        logic [7:0] b;
        int n;
        exp_addr_q.delete(); exp_wdata_q.delete(); zx_tx_q.delete(); zx_rx_exp_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_addr_q.push_back(ADDR_W'((32'(addr) + 32'(i)) % 32'h80000));
            b = (preset_tx.size() == len) ? preset_tx[i] : 8'($urandom);
            if (!dir) begin
                exp_wdata_q.push_back(b);
                zx_tx_q.push_back(b);
            end
        end
        clear_counts();
        data_bit  = 1'b0;
        cur_dir   = dir;
        cfg_addr  = addr;
        cfg_len   = LEN_W'(len);
        cfg_dir   = dir;
        cfg_start = 1'b1;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            if (glitch && n == 4) begin
                cfg_start = 1'b1;
                cfg_addr  = ADDR_W'($urandom);
                cfg_len   = LEN_W'($urandom_range(1, 50));
                cfg_dir   = ~dir;
            end
            tick();
            n++;
        end
        if (n >= 400) check("xfer_timeout", 32'd1, 32'd0);
        repeat (12) tick();
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("aborted", 32'(aborted), 32'(exp_abt));
        check("remaining", 32'(remaining), exp_abt ? 32'(len) : 32'd0);
        check("data_bit_wr_count", 32'(wr_cnt), exp_abt ? 32'd0 : 32'(len));
        check("mem_access_count", 32'(acc_cnt), exp_abt ? 32'd1 : 32'(len));
        if (!exp_abt && dir) check("zx_unread", 32'(zx_rx_exp_q.size()), 32'd0);
        preset_tx.delete();
    endtask

    initial begin
        int dn_at;
        int n;
        rst = 1'b1;
        cfg_addr = '0; cfg_len = '0; cfg_dir = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
        data_reg_out = '0; data_bit = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        abort_on_req = 1'b0;
        clear_counts();

        repeat (3) @(posedge cpu_clock);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_data_bit_wr", 32'(data_bit_wr), 32'd0);
        check("rst_data_bit_in", 32'(data_bit_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_data_reg_in", 32'(data_reg_in), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        check("idle_after_rst", 32'(busy), 32'd0);

        // ZX -> memory, three bytes
        preset_tx = '{8'h11, 8'h22, 8'h33};
        run_xfer(1'b0, 19'h00100, 3, 1'b0, 1'b0);

        // memory -> ZX across the address wrap
        rd_src_q = '{8'hA5, 8'h5A};
        run_xfer(1'b1, 19'h7FFFF, 2, 1'b0, 1'b0);

        // zero length: done in the second cycle after the start cycle
        clear_counts();
        cur_dir = 1'b0;
        cfg_addr = 19'h01234; cfg_len = '0; cfg_dir = 1'b0; cfg_start = 1'b1;
        dn_at = -1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done_cnt != 0 && dn_at < 0) dn_at = k;
        end
        check("len0_done_cycle", 32'(dn_at), 32'd2);
        check("len0_done_pulses", 32'(done_cnt), 32'd1);
        check("len0_mem_req", 32'(req_cycles), 32'd0);
        check("len0_data_bit_wr", 32'(wr_cnt), 32'd0);
        check("len0_aborted", 32'(aborted), 32'd0);

        // abort while the memory request is outstanding
        force_lat    = 3;
        abort_on_req = 1'b1;
        run_xfer(1'b0, 19'h02000, 4, 1'b0, 1'b1);
        check("abort_req_hold", 32'(req_cycles), 32'd5);
        force_lat = -1;

        // start together with abort while idle is ignored
        clear_counts();
        cfg_addr = 19'h00055; cfg_len = 16'd9; cfg_dir = 1'b1;
        cfg_start = 1'b1; cfg_abort = 1'b1;
        repeat (6) tick();
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_remaining", 32'(remaining), 32'd4);
        check("start_abort_aborted", 32'(aborted), 32'd1);
        check("start_abort_done", 32'(done_cnt), 32'd0);
        check("start_abort_req", 32'(req_cycles), 32'd0);

        // start while busy is ignored
        run_xfer(1'b0, 19'h03000, 3, 1'b1, 1'b0);

        // randomized transfers
        for (int t = 0; t < 10; t++) begin
            run_xfer(1'($urandom), ADDR_W'($urandom), int'($urandom_range(1, 6)), 1'b0, 1'b0);
        end

        // reset in the middle of a memory request
        clear_counts();
        force_lat = 20;
        data_bit = 1'b0; cur_dir = 1'b1;
        exp_addr_q.delete(); zx_rx_exp_q.delete();
        cfg_addr = 19'h00005; cfg_len = 16'd3; cfg_dir = 1'b1; cfg_start = 1'b1;
        n = 0;
        while (req_cycles == 0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("mem_req_timeout", 32'd1, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        pend = 1'b0;
        force_lat = -1;
        repeat (2) tick();
        rst = 1'b0;
        done_cnt = 0; req_cycles = 0;
        mem_ack = 1'b1;
        repeat (5) tick();
        check("orphan_ack_busy", 32'(busy), 32'd0);
        check("orphan_ack_req", 32'(req_cycles), 32'd0);
        check("orphan_ack_done", 32'(done_cnt), 32'd0);
        check("orphan_ack_remaining", 32'(remaining), 32'd0);
        check("orphan_ack_addr", 32'(mem_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
